player_ctrl: RTL
================

# player_ctrl

Parametrised per-player controller for the street-fighter game core. It turns debounced button levels into a registered action/state word plus movement and attack requests. It owns the player's health and shield meters, applies incoming hits from the game arbiter, and enforces timed jump, punch, hit-stun and knock-out behaviour. Two instances, one per player, sit between the input synchroniser and the game/sprite logic.

## Interface
- PLAYER_ID, 0: initial facing after reset (0 = right, 1 = left).
- HEALTH_W, 8: width of the health, shield and damage buses.
- HEALTH_MAX, 100: health after reset.
- SHIELD_MAX, 100: shield after reset; also the saturation ceiling.
- JUMP_CYCLES, 100_000_000: duration of a jump, in clocks.
- PUNCH_CYCLES, 25_000_000: duration of a punch, in clocks.
- HITSTUN_CYCLES, 20_000_000: duration of hit-stun, in clocks.
- SHIELD_TICK, 1_000_000: clocks per shield regen/drain step.
- CHIP_SHIFT, 2: a shielded hit costs health of damage >> CHIP_SHIFT.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- left_btn, right_btn, up_btn, down_btn, attack_btn, shield_btn  in  1 each  synchronised button levels.
- hit_valid  in  1  one-cycle strobe from the game arbiter: this player has been struck.
- hit_damage  in  HEALTH_W  damage amount; valid only with hit_valid.
- attack_request  out  1  one-cycle pulse when a punch starts.
- jump_request  out  1  one-cycle pulse when a jump starts.
- left_request, right_request  out  1  level, high while moving in WALKING or JUMPING.
- action  out  9  {dir, one-hot state}, with dir = 1 meaning facing left.
- jump_descending  out  1  high during the second half of a jump.
- health, shield  out  HEALTH_W  current meter values.
- ko  out  1  sticky once health reaches 0.

## Operation
- One-hot states: WALKING 0x01, CROUCHING 0x02, SHIELDING 0x04, JUMPING 0x08, PUNCHING 0x10, STANDING 0x20, HITSTUN 0x40, KO 0x80.
- Direction: right_btn sets dir to 0, otherwise left_btn sets it to 1, otherwise dir holds. Direction updates in every state except HITSTUN and KO.
- Grounded states are STANDING, WALKING, CROUCHING and SHIELDING. In a grounded state, the next state is chosen by priority:
  - down_btn → CROUCHING.
  - left_btn or right_btn → WALKING.
  - shield_btn with shield > 0 → SHIELDING.
  - up_btn → JUMPING.
  - rising edge of attack_btn → PUNCHING.
  - otherwise → STANDING.
- JUMPING: lasts exactly JUMP_CYCLES, then re-evaluates the grounded priority. jump_descending is high for the last JUMP_CYCLES/2 cycles (integer division). Left/right requests remain active during the jump.
- PUNCHING: lasts exactly PUNCH_CYCLES. Holding attack_btn does not retrigger; a new punch needs a release and a fresh press.
- Shield regen/drain: a free-running tick counter of SHIELD_TICK clocks drives it.
  - While in SHIELDING, shield decrements by 1 per tick.
  - In any other state except KO, shield increments by 1 per tick, saturating at SHIELD_MAX.
  - When shield reaches 0, SHIELDING is left on the next cycle using the grounded priority.
- Hit handling, evaluated when hit_valid is high; a hit takes precedence over any button decision in the same cycle:
  - In SHIELDING with shield > 0: health -= hit_damage >> CHIP_SHIFT and shield -= hit_damage, both saturating at 0. The state stays SHIELDING.
  - Otherwise: health -= hit_damage, saturating at 0. The state becomes HITSTUN and the stun timer reloads, including when already in HITSTUN or when a jump or punch is aborted. A hit_damage of 0 still causes stun.
  - If the resulting health is 0, the state becomes KO instead.
  - In KO, hits are ignored.
- KO: absorbing state; only reset leaves it. ko = 1, all requests are 0, and dir and the meters are frozen.

## Timing
- All outputs are registered. Inputs sampled at edge N are reflected on the outputs after edge N.
- A timed state (jump, punch, stun) is visible on action for exactly its parameter's number of cycles.
- attack_request and jump_request are high only in the first cycle of PUNCHING and JUMPING respectively.
- Reset values:
  - action = {PLAYER_ID, STANDING}
  - health = HEALTH_MAX, shield = SHIELD_MAX
  - all requests = 0, jump_descending = 0, ko = 0
  - all timers and the tick counter = 0; the attack edge register is cleared.
- Reset asserted mid-jump, mid-punch, mid-stun or in KO returns to the reset values on the next edge.

## Structure
- Package sf_pkg holds the one-hot state constants and the action bit index of dir. The same package is shared with sprite rendering.
- Sub-module action_timer: a loadable down-counter with ports load, load_value, running, halfway and done. It is instantiated once and shared between jump, punch and stun, since these are mutually exclusive.
- The shield tick counter and the meter arithmetic are inline, widened by one bit for the saturation checks.

## Test plan
All scenarios use JUMP_CYCLES=8, PUNCH_CYCLES=4, HITSTUN_CYCLES=3, SHIELD_TICK=2, SHIELD_MAX=10, HEALTH_MAX=100, PLAYER_ID=1.
- Reset, then up_btn for 1 cycle → action 0x108 for exactly 8 cycles; jump_request pulses once; jump_descending is high in cycles 5–8; then action 0x120.
- attack_btn held for 20 cycles → exactly one attack_request, PUNCHING for 4 cycles, then STANDING. Release and re-press → a second punch.
- shield_btn held, no hits → shield drops 10→0 over 20 cycles, then action leaves SHIELDING. After release, shield regains 1 every 2 cycles up to 10.
- hit_damage=40 while SHIELDING → health 90, shield 0 (saturated), state stays SHIELDING that cycle. Then hit_damage=40 while STANDING → health 50, HITSTUN for 3 cycles.
- hit arriving on the same cycle as up_btn → HITSTUN with no jump_request. A hit mid-jump aborts the jump.
- hits totalling ≥100 → KO with ko=1; further hits and buttons are ignored. Reset → health 100, action 0x120.

Source files
------------

// File: rtl/sf_pkg.sv
// Shared street-fighter definitions: one-hot player states and action word layout.
// The sprite renderer imports this package too, so the state encodings are fixed.
package sf_pkg;

  typedef enum logic [7:0] {
    ST_WALKING   = 8'h01,
    ST_CROUCHING = 8'h02,
    ST_SHIELDING = 8'h04,
    ST_JUMPING   = 8'h08,
    ST_PUNCHING  = 8'h10,
    ST_STANDING  = 8'h20,
    ST_HITSTUN   = 8'h40,
    ST_KO        = 8'h80
  } state_t;

  localparam int ACTION_W       = 9;
  localparam int ACTION_DIR_BIT = 8;

endpackage

// File: rtl/action_timer.sv
// Loadable down-counter for timed player states (jump, punch, hit-stun).
// Counts load_value..1 while the state is active; done marks its final cycle.
module action_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         running,
  output logic         halfway,
  output logic         done
);

  logic [W-1:0] count;
  logic [W-1:0] half;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      half  <= '0;
    end else if (load) begin
      count <= load_value;
      half  <= load_value >> 1;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign running = (count != '0);
  // Last floor(load_value/2) cycles of the timed state.
  assign halfway = running && (count <= half);
  assign done    = (count == W'(1));

endmodule

// File: rtl/player_ctrl.sv
// Per-player controller: button levels -> action word, requests, health/shield meters.
//   state      | meaning
//   WALKING    | left/right held, moving
//   CROUCHING  | down held
//   SHIELDING  | shield held with shield meter > 0, meter drains
//   JUMPING    | timed jump, left/right still steer
//   PUNCHING   | timed punch started by an attack press
//   STANDING   | idle on the ground
//   HITSTUN    | timed stun after an unshielded hit
//   KO         | health exhausted, frozen until reset
module player_ctrl
  import sf_pkg::*;
#(
  parameter int PLAYER_ID      = 0,
  parameter int HEALTH_W       = 8,
  parameter int HEALTH_MAX     = 100,
  parameter int SHIELD_MAX     = 100,
  parameter int JUMP_CYCLES    = 100_000_000,
  parameter int PUNCH_CYCLES   = 25_000_000,
  parameter int HITSTUN_CYCLES = 20_000_000,
  parameter int SHIELD_TICK    = 1_000_000,
  parameter int CHIP_SHIFT     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                left_btn,
  input  logic                right_btn,
  input  logic                up_btn,
  input  logic                down_btn,
  input  logic                attack_btn,
  input  logic                shield_btn,
  input  logic                hit_valid,
  input  logic [HEALTH_W-1:0] hit_damage,
  output logic                attack_request,
  output logic                jump_request,
  output logic                left_request,
  output logic                right_request,
  output logic [ACTION_W-1:0] action,
  output logic                jump_descending,
  output logic [HEALTH_W-1:0] health,
  output logic [HEALTH_W-1:0] shield,
  output logic                ko
);

  localparam int TMAX_JP = (JUMP_CYCLES > PUNCH_CYCLES) ? JUMP_CYCLES : PUNCH_CYCLES;
  localparam int TMAX    = (TMAX_JP > HITSTUN_CYCLES) ? TMAX_JP : HITSTUN_CYCLES;
  localparam int TIMER_W = $clog2(TMAX + 1);
  localparam int TICK_W  = (SHIELD_TICK > 1) ? $clog2(SHIELD_TICK) : 1;

  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] a,
                                                  input logic [HEALTH_W-1:0] b);
    logic [HEALTH_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[HEALTH_W] ? '0 : d[HEALTH_W-1:0];
  endfunction

  state_t               state, state_next, grounded;
  logic                 dir, dir_next;
  logic [HEALTH_W-1:0]  health_next, shield_next, shield_drained;
  logic [TICK_W-1:0]    tick_cnt;
  logic                 tick, attack_prev, attack_rise, timed;
  logic                 timer_load, timer_running, timer_halfway, timer_done;
  logic [TIMER_W-1:0]   timer_value;
  logic                 attack_start, jump_start, left_next, right_next, moving_next;

  assign tick        = (tick_cnt == '0);
  assign attack_rise = attack_btn && !attack_prev;
  assign timed       = (state == ST_JUMPING) || (state == ST_PUNCHING) || (state == ST_HITSTUN);

  always_comb begin
    grounded = ST_STANDING;
    if (down_btn)                          grounded = ST_CROUCHING;
    else if (left_btn || right_btn)        grounded = ST_WALKING;
    else if (shield_btn && shield != '0)   grounded = ST_SHIELDING;
    else if (up_btn)                       grounded = ST_JUMPING;
    else if (attack_rise)                  grounded = ST_PUNCHING;
  end

  always_comb begin
    state_next     = state;
    dir_next       = dir;
    health_next    = health;
    shield_next    = shield;
    shield_drained = sat_sub(shield, HEALTH_W'(tick));
    timer_load     = 1'b0;
    timer_value    = '0;
    attack_start   = 1'b0;
    jump_start     = 1'b0;

    if (state != ST_KO) begin
      if (state != ST_HITSTUN) begin
        if (right_btn)     dir_next = 1'b0;
        else if (left_btn) dir_next = 1'b1;
      end

      if (state == ST_SHIELDING)
        shield_next = shield_drained;
      else if (tick && (shield < HEALTH_W'(SHIELD_MAX)))
        shield_next = shield + 1'b1;

      if (hit_valid) begin
        if ((state == ST_SHIELDING) && (shield != '0)) begin
          health_next = sat_sub(health, hit_damage >> CHIP_SHIFT);
          shield_next = sat_sub(shield_drained, hit_damage);
        end else begin
          health_next = sat_sub(health, hit_damage);
          state_next  = ST_HITSTUN;
          timer_load  = 1'b1;
          timer_value = TIMER_W'(HITSTUN_CYCLES);
        end
        if (health_next == '0) state_next = ST_KO;
      end else if (!timed || timer_done || !timer_running) begin
        state_next = grounded;
        if (grounded == ST_JUMPING) begin
          jump_start  = 1'b1;
          timer_load  = 1'b1;
          timer_value = TIMER_W'(JUMP_CYCLES);
        end else if (grounded == ST_PUNCHING) begin
          attack_start = 1'b1;
          timer_load   = 1'b1;
          timer_value  = TIMER_W'(PUNCH_CYCLES);
        end
      end
    end

    moving_next = (state_next == ST_WALKING) || (state_next == ST_JUMPING);
    left_next   = moving_next && left_btn && !right_btn;
    right_next  = moving_next && right_btn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_STANDING;
      dir            <= 1'(PLAYER_ID);
      health         <= HEALTH_W'(HEALTH_MAX);
      shield         <= HEALTH_W'(SHIELD_MAX);
      tick_cnt       <= '0;
      attack_prev    <= 1'b0;
      attack_request <= 1'b0;
      jump_request   <= 1'b0;
      left_request   <= 1'b0;
      right_request  <= 1'b0;
    end else begin
      state          <= state_next;
      dir            <= dir_next;
      health         <= health_next;
      shield         <= shield_next;
      tick_cnt       <= tick ? TICK_W'(SHIELD_TICK - 1) : tick_cnt - 1'b1;
      attack_prev    <= attack_btn;
      attack_request <= attack_start;
      jump_request   <= jump_start;
      left_request   <= left_next;
      right_request  <= right_next;
    end
  end

  action_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .running    (timer_running),
    .halfway    (timer_halfway),
    .done       (timer_done)
  );

  assign action          = {dir, state};
  assign jump_descending = (state == ST_JUMPING) && timer_halfway;
  assign ko              = (state == ST_KO);

endmodule
